microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Parametrised next-generation control unit for the downsampling processor.
- Sequences fetch, decode, execute and memory phases, and drives the A/B/C bus selects, ALU opcode, memory enables, increment enables and register clears.
- Memory operations use a `mem_ready` handshake with a timeout instead of fixed wait states.
- Adds illegal-opcode trapping, a single-step halt mode and `busy`/`mem_error` status.

Parameters:
- INSTR_W, 32, instruction width.
- OPC_W, 6, decoded opcode width.
- SEL_W, 3, A/B bus select width.
- CSEL_W, 4, C bus select width.
- INC_W, 5, increment-enable width; bit 0 = PC.
- CLR_W, 6, register-clear width.
- DST_LSB, 23, LSB of the destination/A-select field.
- BSEL_LSB, 19, LSB of the B-select field.
- NFLAG_BIT, 18, branch-on-negative bit.
- ZFLAG_BIT, 17, branch-on-zero bit.
- IMM_ASEL, 7, A select for the immediate.
- AC_SEL, 3, A select for AC.
- MAR_CSEL, 12, C select for MAR.
- AC_CSEL, 11, C select for AC.
- PC_CSEL, 14, C select for PC.
- MEM_TIMEOUT, 15, maximum wait cycles for `mem_ready`.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching.
- step_mode  in  1  when 1, halt in STEP after each instruction.
- step  in  1  1-cycle pulse that releases STEP.
- opcode  in  OPC_W  decoded opcode of the current instruction.
- instruction  in  INSTR_W  current instruction word.
- n  in  1  ALU negative flag.
- z  in  1  ALU zero flag.
- mem_ready  in  1  memory completion.
- alu_op  out  3  ALU operation.
- abus_en  out  SEL_W  A bus select.
- bbus_en  out  SEL_W  B bus select.
- cbus_en  out  CSEL_W  C bus select.
- mem_en  out  4  [3] fetch, [2] load via MAR, [1] load via register, [0] store.
- inc_en  out  INC_W  increment enables.
- reg_clr  out  CLR_W  register clears.
- busy  out  1  high in any state except IDLE, HALT and ERROR.
- end_process  out  1  high in HALT.
- mem_error  out  1  high in ERROR.

Behaviour:
- Single-edge synchronous FSM. All outputs are registered and reflect the current state.
- Outputs not listed for a state are 0.
- Reset, including mid-operation: state goes to IDLE, all outputs 0, wait counter cleared. Takes priority over every other input.
- Bus and destination fields:
  - A = instruction[DST_LSB+SEL_W-1:DST_LSB]
  - D = instruction[DST_LSB+CSEL_W-1:DST_LSB]
  - B = instruction[BSEL_LSB+SEL_W-1:BSEL_LSB]
- IDLE: `reg_clr` all 1. `start` moves to FETCH on the next cycle.
- FETCH: `mem_en`=1000.
  - Wait counter increments each cycle while `mem_ready`=0.
  - `mem_ready`=1 → EXEC, with `inc_en[0]`=1 for exactly that transition cycle.
- Execute states, by opcode:
  - 0 NOP: no outputs.
  - 1 RSET: `reg_clr` = {0, instruction[26:22]}.
  - 6 MVARS: `abus_en`=1, `cbus_en`=MAR_CSEL.
  - 7 MVARD: `abus_en`=2, `cbus_en`=MAR_CSEL.
  - 8 JUMP: `abus_en`=IMM_ASEL, `cbus_en`=PC_CSEL.
  - 10 MVACO: `abus_en`=AC_SEL, `cbus_en`=D.
  - 11 MVACA: `abus_en`=A, `cbus_en`=AC_CSEL.
  - 12 MVACB: `alu_op`=1, `bbus_en`=A, `cbus_en`=AC_CSEL.
  - 13 INC: `inc_en` = {D, 0}.
  - 14–21 arithmetic: `alu_op` = ADD 2 / SUB 3 / MUL 4 / DIV 5.
    - Even opcodes (K forms): `bbus_en`=IMM_ASEL.
    - Odd opcodes (R forms): `bbus_en`=B.
    - `abus_en`=A, `cbus_en`=D.
  - 22 SHFR: `alu_op`=6, `abus_en`=AC_SEL, `cbus_en`=AC_CSEL.
  - 23 SFTL: `alu_op`=7, `abus_en`=AC_SEL, `cbus_en`=AC_CSEL.
  - All of the above take one cycle, then go to NEXT.
- Memory opcodes:
  - 2 LOADR: MEM_WAIT with `mem_en`=0010.
  - 4 STORR: MEM_WAIT with `mem_en`=0001.
  - 3 LOADK / 5 STORK: first one MAR cycle (`abus_en`=IMM_ASEL, `cbus_en`=MAR_CSEL), then MEM_WAIT with `mem_en`=0100 (LOADK) or 0001 (STORK).
  - MEM_WAIT holds its `mem_en` until `mem_ready`=1, then goes to NEXT.
- 9 JMPX:
  - BR1 then BR2, each driving `alu_op`=3, `abus_en`=A, `bbus_en`=B.
  - At the end of BR2, sample `n` and `z`.
  - Taken if (instruction[NFLAG_BIT] & `n`) | (instruction[ZFLAG_BIT] & `z`).
  - Taken → BRT: `abus_en`=IMM_ASEL, `cbus_en`=PC_CSEL, 1 cycle, then NEXT.
  - Not taken → NEXT.
- 24 END: HALT. `reg_clr` all 1, `end_process`=1. Only `reset` exits.
- Any other opcode: ERROR.
- NEXT (combinational decision, no cycle):
  - `step_mode`=1 → STEP, where all outputs are 0 and `step` moves to FETCH.
  - Otherwise → FETCH.
- Wait counter:
  - Cleared on entry to FETCH and MEM_WAIT.
  - Width is ceil(log2(MEM_TIMEOUT+1)).
  - Counter reaching MEM_TIMEOUT with `mem_ready` still 0 → ERROR.
  - `mem_ready` on the same cycle the count reaches MEM_TIMEOUT counts as success.
- ERROR: `mem_error`=1 and `reg_clr`=0. Ignores `start` and `step`; only `reset` exits.
- `start` and `step` are ignored outside IDLE and STEP respectively.

Test Plan:
- `reset`, `start`, FETCH with `mem_ready` after 3 cycles, opcode 15 with A=2, B=5 → `alu_op`=2, `abus_en`=2, `bbus_en`=5, `cbus_en`=2 for 1 cycle; `inc_en[0]` pulsed exactly once.
- Opcode 9 with N-bit=1 and `n`=1 at the end of BR2 → BRT drives `abus_en`=7, `cbus_en`=14; repeat with `n`=0 and `z`=0 → FETCH follows BR2 directly.
- Opcode 3 with `mem_ready` never asserted → MAR cycle, then 15 wait cycles, then `mem_error`=1 held; `start` has no effect.
- Opcode 40 → ERROR on the cycle after decode; `busy`=0 and `mem_error`=1.
- `reset` asserted during MEM_WAIT of opcode 4 → next cycle all outputs 0 and state IDLE; `start` restarts cleanly.
- `step_mode`=1, run opcode 0 then opcode 24 → STEP entered with `busy`=1; `step` pulse fetches opcode 24 → `end_process`=1 and `reg_clr`=111111 held.

Source files
------------

// File: rtl/microcode_sequencer_if.sv
// Control/status bundle between the microcode sequencer and the datapath.
// The sequencer is the master: it drives bus selects, ALU opcode, memory and
// register controls, and receives instruction, flags and memory completion.
interface microcode_sequencer_if #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6,
  parameter int SEL_W   = 3,
  parameter int CSEL_W  = 4,
  parameter int INC_W   = 5,
  parameter int CLR_W   = 6
);
  logic               start;
  logic               step_mode;
  logic               step;
  logic [OPC_W-1:0]   opcode;
  logic [INSTR_W-1:0] instruction;
  logic               n;
  logic               z;
  logic               mem_ready;
  logic [2:0]         alu_op;
  logic [SEL_W-1:0]   abus_en;
  logic [SEL_W-1:0]   bbus_en;
  logic [CSEL_W-1:0]  cbus_en;
  logic [3:0]         mem_en;
  logic [INC_W-1:0]   inc_en;
  logic [CLR_W-1:0]   reg_clr;
  logic               busy;
  logic               end_process;
  logic               mem_error;

  modport master (
    input  start, step_mode, step, opcode, instruction, n, z, mem_ready,
    output alu_op, abus_en, bbus_en, cbus_en, mem_en, inc_en, reg_clr,
           busy, end_process, mem_error
  );

  modport slave (
    output start, step_mode, step, opcode, instruction, n, z, mem_ready,
    input  alu_op, abus_en, bbus_en, cbus_en, mem_en, inc_en, reg_clr,
           busy, end_process, mem_error
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the downsampling processor.
// All outputs are registered: the combinational block computes the next state
// together with the outputs that belong to it, so registered outputs always
// describe the state currently held.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | registers held cleared, waiting for start
// FETCH    | instruction fetch, waiting on mem_ready
// EXEC     | single-cycle execute of a non-memory, non-branch opcode
// MAR      | immediate address loaded into MAR (LOADK / STORK)
// MEM_WAIT | memory access held until mem_ready or timeout
// BR1/BR2  | compare cycles of JMPX; flags sampled at end of BR2
// BRT      | branch taken, immediate written to PC
// STEP     | single-step pause, step pulse resumes fetching
// HALT     | END executed, only reset leaves
// ERROR    | illegal opcode or memory timeout, only reset leaves
module microcode_sequencer #(
  parameter int INSTR_W     = 32,
  parameter int OPC_W       = 6,
  parameter int SEL_W       = 3,
  parameter int CSEL_W      = 4,
  parameter int INC_W       = 5,
  parameter int CLR_W       = 6,
  parameter int DST_LSB     = 23,
  parameter int BSEL_LSB    = 19,
  parameter int NFLAG_BIT   = 18,
  parameter int ZFLAG_BIT   = 17,
  parameter int IMM_ASEL    = 7,
  parameter int AC_SEL      = 3,
  parameter int MAR_CSEL    = 12,
  parameter int AC_CSEL     = 11,
  parameter int PC_CSEL     = 14,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  microcode_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_RSET  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LOADR = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LOADK = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_STORR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_STORK = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_MVARS = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MVARD = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_JMPX  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_MVACO = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_MVACA = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_MVACB = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_INC   = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_ADDK  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_ADDR  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_SUBK  = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_SUBR  = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_MULK  = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_MULR  = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_DIVK  = OPC_W'(20);
  localparam logic [OPC_W-1:0] OP_DIVR  = OPC_W'(21);
  localparam logic [OPC_W-1:0] OP_SHFR  = OPC_W'(22);
  localparam logic [OPC_W-1:0] OP_SFTL  = OPC_W'(23);
  localparam logic [OPC_W-1:0] OP_END   = OPC_W'(24);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MAR, S_MEM_WAIT,
    S_BR1, S_BR2, S_BRT, S_STEP, S_HALT, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [SEL_W-1:0]    abus_en_q, abus_en_d;
  logic [SEL_W-1:0]    bbus_en_q, bbus_en_d;
  logic [CSEL_W-1:0]   cbus_en_q, cbus_en_d;
  logic [3:0]          mem_en_q, mem_en_d;
  logic [INC_W-1:0]    inc_en_q, inc_en_d;
  logic [CLR_W-1:0]    reg_clr_q, reg_clr_d;
  logic                busy_q, busy_d;
  logic                end_process_q, end_process_d;
  logic                mem_error_q, mem_error_d;

  logic [SEL_W-1:0]    fld_a;
  logic [SEL_W-1:0]    fld_b;
  logic [CSEL_W-1:0]   fld_d;
  logic [OPC_W-1:0]    arith_off;
  logic                br_taken;
  logic                timeout;
  logic                unused_instr_bits;

  assign fld_a     = bus.instruction[DST_LSB +: SEL_W];
  assign fld_d     = bus.instruction[DST_LSB +: CSEL_W];
  assign fld_b     = bus.instruction[BSEL_LSB +: SEL_W];
  assign arith_off = bus.opcode - OP_ADDK;
  assign br_taken  = (bus.instruction[NFLAG_BIT] & bus.n) |
                     (bus.instruction[ZFLAG_BIT] & bus.z);
  // Last allowed waiting cycle: a miss here means MEM_TIMEOUT cycles elapsed.
  assign timeout   = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign unused_instr_bits = ^{bus.instruction[INSTR_W-1:27], bus.instruction[16:0]};

  // Next state plus the registered outputs that belong to that state.
  always_comb begin
    logic go_next;
    logic decode;
    logic pc_inc;
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_op_d      = '0;
    abus_en_d     = '0;
    bbus_en_d     = '0;
    cbus_en_d     = '0;
    mem_en_d      = '0;
    inc_en_d      = '0;
    reg_clr_d     = '0;
    busy_d        = 1'b0;
    end_process_d = 1'b0;
    mem_error_d   = 1'b0;
    go_next       = 1'b0;
    decode        = 1'b0;
    pc_inc        = 1'b1;

    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (bus.mem_ready)  decode = 1'b1;
        else if (timeout)   state_d = S_ERROR;
        else                cnt_d = cnt_q + 1'b1;
      end
      S_EXEC, S_BRT: go_next = 1'b1;
      S_MAR: begin
        state_d  = S_MEM_WAIT;
        cnt_d    = '0;
        mem_en_d = (bus.opcode == OP_LOADK) ? 4'b0100 : 4'b0001;
      end
      S_MEM_WAIT: begin
        if (bus.mem_ready) go_next = 1'b1;
        else if (timeout)  state_d = S_ERROR;
        else begin
          cnt_d    = cnt_q + 1'b1;
          mem_en_d = mem_en_q;
        end
      end
      S_BR1: begin
        state_d   = S_BR2;
        alu_op_d  = 3'd3;
        abus_en_d = fld_a;
        bbus_en_d = fld_b;
      end
      S_BR2: begin
        if (br_taken) begin
          state_d   = S_BRT;
          abus_en_d = SEL_W'(IMM_ASEL);
          cbus_en_d = CSEL_W'(PC_CSEL);
        end else begin
          go_next = 1'b1;
        end
      end
      S_STEP: if (bus.step) begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      default: ;
    endcase

    if (go_next) begin
      cnt_d   = '0;
      state_d = bus.step_mode ? S_STEP : S_FETCH;
    end

    if (decode) begin
      state_d = S_EXEC;
      case (bus.opcode)
        OP_NOP: ;
        OP_RSET: reg_clr_d = CLR_W'(bus.instruction[26:22]);
        OP_LOADR, OP_STORR: begin
          state_d  = S_MEM_WAIT;
          cnt_d    = '0;
          mem_en_d = (bus.opcode == OP_LOADR) ? 4'b0010 : 4'b0001;
        end
        OP_LOADK, OP_STORK: begin
          state_d   = S_MAR;
          abus_en_d = SEL_W'(IMM_ASEL);
          cbus_en_d = CSEL_W'(MAR_CSEL);
        end
        OP_MVARS, OP_MVARD: begin
          abus_en_d = (bus.opcode == OP_MVARS) ? SEL_W'(1) : SEL_W'(2);
          cbus_en_d = CSEL_W'(MAR_CSEL);
        end
        OP_JUMP: begin
          abus_en_d = SEL_W'(IMM_ASEL);
          cbus_en_d = CSEL_W'(PC_CSEL);
        end
        OP_JMPX: begin
          state_d   = S_BR1;
          alu_op_d  = 3'd3;
          abus_en_d = fld_a;
          bbus_en_d = fld_b;
        end
        OP_MVACO: begin
          abus_en_d = SEL_W'(AC_SEL);
          cbus_en_d = fld_d;
        end
        OP_MVACA: begin
          abus_en_d = fld_a;
          cbus_en_d = CSEL_W'(AC_CSEL);
        end
        OP_MVACB: begin
          alu_op_d  = 3'd1;
          bbus_en_d = fld_a;
          cbus_en_d = CSEL_W'(AC_CSEL);
        end
        OP_INC: inc_en_d = INC_W'({fld_d, 1'b0});
        OP_ADDK, OP_ADDR, OP_SUBK, OP_SUBR,
        OP_MULK, OP_MULR, OP_DIVK, OP_DIVR: begin
          // Opcode pairs map onto ADD..DIV; the odd member takes B from a register.
          alu_op_d  = 3'd2 + {1'b0, arith_off[2:1]};
          abus_en_d = fld_a;
          bbus_en_d = arith_off[0] ? fld_b : SEL_W'(IMM_ASEL);
          cbus_en_d = fld_d;
        end
        OP_SHFR, OP_SFTL: begin
          alu_op_d  = (bus.opcode == OP_SHFR) ? 3'd6 : 3'd7;
          abus_en_d = SEL_W'(AC_SEL);
          cbus_en_d = CSEL_W'(AC_CSEL);
        end
        OP_END: begin
          state_d = S_HALT;
          pc_inc  = 1'b0;
        end
        default: begin
          state_d = S_ERROR;
          pc_inc  = 1'b0;
        end
      endcase
      inc_en_d[0] = inc_en_d[0] | pc_inc;
    end

    case (state_d)
      S_IDLE:  reg_clr_d = '1;
      S_FETCH: mem_en_d  = 4'b1000;
      S_HALT: begin
        reg_clr_d     = '1;
        end_process_d = 1'b1;
      end
      S_ERROR: mem_error_d = 1'b1;
      default: ;
    endcase

    busy_d = !(state_d inside {S_IDLE, S_HALT, S_ERROR});
  end

  // State, wait counter and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      alu_op_q      <= '0;
      abus_en_q     <= '0;
      bbus_en_q     <= '0;
      cbus_en_q     <= '0;
      mem_en_q      <= '0;
      inc_en_q      <= '0;
      reg_clr_q     <= '0;
      busy_q        <= 1'b0;
      end_process_q <= 1'b0;
      mem_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_op_q      <= alu_op_d;
      abus_en_q     <= abus_en_d;
      bbus_en_q     <= bbus_en_d;
      cbus_en_q     <= cbus_en_d;
      mem_en_q      <= mem_en_d;
      inc_en_q      <= inc_en_d;
      reg_clr_q     <= reg_clr_d;
      busy_q        <= busy_d;
      end_process_q <= end_process_d;
      mem_error_q   <= mem_error_d;
    end
  end

  assign bus.alu_op      = alu_op_q;
  assign bus.abus_en     = abus_en_q;
  assign bus.bbus_en     = bbus_en_q;
  assign bus.cbus_en     = cbus_en_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.inc_en      = inc_en_q;
  assign bus.reg_clr     = reg_clr_q;
  assign bus.busy        = busy_q;
  assign bus.end_process = end_process_q;
  assign bus.mem_error   = mem_error_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer: directed scenarios plus randomized
// instruction streams checked cycle by cycle against a phase-level model.
module tb_microcode_sequencer;

  typedef struct packed {
    logic [2:0] alu;
    logic [2:0] abus;
    logic [2:0] bbus;
    logic [3:0] cbus;
    logic [3:0] mem;
    logic [4:0] inc;
    logic [5:0] clr;
    logic       busy;
    logic       endp;
    logic       merr;
  } outs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  microcode_sequencer_if bus_if ();

  microcode_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic outs_t observed();
    outs_t o;
    o.alu  = bus_if.alu_op;
    o.abus = bus_if.abus_en;
    o.bbus = bus_if.bbus_en;
    o.cbus = bus_if.cbus_en;
    o.mem  = bus_if.mem_en;
    o.inc  = bus_if.inc_en;
    o.clr  = bus_if.reg_clr;
    o.busy = bus_if.busy;
    o.endp = bus_if.end_process;
    o.merr = bus_if.mem_error;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t o;
    o = observed();
    n_checks++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, exp);
    end
  endtask

  // Expected output vectors for the fixed-function states.
  function automatic outs_t zero_o();
    outs_t e = '0;
    return e;
  endfunction
  function automatic outs_t idle_o();
    outs_t e = '0;
    e.clr = 6'h3F;
    return e;
  endfunction
  function automatic outs_t fetch_o();
    outs_t e = '0;
    e.mem = 4'b1000; e.busy = 1'b1;
    return e;
  endfunction
  function automatic outs_t step_o();
    outs_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction
  function automatic outs_t halt_o();
    outs_t e = '0;
    e.clr = 6'h3F; e.endp = 1'b1;
    return e;
  endfunction
  function automatic outs_t err_o();
    outs_t e = '0;
    e.merr = 1'b1;
    return e;
  endfunction
  function automatic outs_t mem_o(input logic [3:0] m);
    outs_t e = '0;
    e.mem = m; e.busy = 1'b1;
    return e;
  endfunction
  function automatic outs_t brt_o();
    outs_t e = '0;
    e.abus = 3'd7; e.cbus = 4'd14; e.busy = 1'b1;
    return e;
  endfunction
  function automatic outs_t br_o(input logic [31:0] ins);
    outs_t e = '0;
    e.alu = 3'd3; e.abus = ins[25:23]; e.bbus = ins[21:19]; e.busy = 1'b1;
    return e;
  endfunction

  // First cycle after a successful fetch: the opcode's own controls plus the PC increment.
  function automatic outs_t first_o(input int opc, input logic [31:0] ins);
    outs_t e;
    logic [2:0] fa;
    logic [2:0] fb;
    logic [3:0] fd;
    fa = ins[25:23];
    fd = ins[26:23];
    fb = ins[21:19];
    e = '0;
    e.busy = 1'b1;
    case (opc)
      1:  e.clr = {1'b0, ins[26:22]};
      2:  e.mem = 4'b0010;
      4:  e.mem = 4'b0001;
      3, 5: begin e.abus = 3'd7; e.cbus = 4'd12; end
      6:  begin e.abus = 3'd1; e.cbus = 4'd12; end
      7:  begin e.abus = 3'd2; e.cbus = 4'd12; end
      8:  begin e.abus = 3'd7; e.cbus = 4'd14; end
      9:  e = br_o(ins);
      10: begin e.abus = 3'd3; e.cbus = fd; end
      11: begin e.abus = fa; e.cbus = 4'd11; end
      12: begin e.alu = 3'd1; e.bbus = fa; e.cbus = 4'd11; end
      13: e.inc = {fd, 1'b0};
      22: begin e.alu = 3'd6; e.abus = 3'd3; e.cbus = 4'd11; end
      23: begin e.alu = 3'd7; e.abus = 3'd3; e.cbus = 4'd11; end
      default: if (opc >= 14 && opc <= 21) begin
        e.alu  = 3'(2 + (opc - 14) / 2);
        e.abus = fa;
        e.bbus = (opc % 2 == 0) ? 3'd7 : fb;
        e.cbus = fd;
      end
    endcase
    e.inc[0] = 1'b1;
    return e;
  endfunction

  // Runs one legal instruction starting in FETCH and checks every cycle.
  task automatic run_instr(input int opc, input logic [31:0] ins, input int fw,
                           input int mw, input logic nn, input logic zz,
                           input logic stepm);
    logic [3:0] m;
    bus_if.opcode      = 6'(opc);
    bus_if.instruction = ins;
    bus_if.mem_ready   = 1'b0;
    for (int i = 0; i < fw; i++) begin
      tick();
      check("fetch_wait", fetch_o());
    end
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    check($sformatf("first_op%0d", opc), first_o(opc, ins));
    if (opc >= 2 && opc <= 5) begin
      m = (opc == 2) ? 4'b0010 : (opc == 3) ? 4'b0100 : 4'b0001;
      if (opc == 3 || opc == 5) begin
        tick();
        check("mem_entry", mem_o(m));
      end
      for (int i = 0; i < mw; i++) begin
        tick();
        check("mem_wait", mem_o(m));
      end
      bus_if.mem_ready = 1'b1;
      tick();
      bus_if.mem_ready = 1'b0;
    end else if (opc == 9) begin
      tick();
      check("br2", br_o(ins));
      bus_if.n = nn;
      bus_if.z = zz;
      tick();
      bus_if.n = 1'b0;
      bus_if.z = 1'b0;
      if ((ins[18] & nn) | (ins[17] & zz)) begin
        check("brt", brt_o());
        tick();
      end
    end else begin
      tick();
    end
    check("after_instr", stepm ? step_o() : fetch_o());
  endtask

  initial begin
    logic [31:0] ins;
    int          opc;
    bus_if.start       = 1'b0;
    bus_if.step_mode   = 1'b0;
    bus_if.step        = 1'b0;
    bus_if.opcode      = '0;
    bus_if.instruction = '0;
    bus_if.n           = 1'b0;
    bus_if.z           = 1'b0;
    bus_if.mem_ready   = 1'b0;

    // Reset and idle.
    reset = 1'b1;
    tick(); tick();
    check("reset", zero_o());
    reset = 1'b0;
    tick();
    check("idle", idle_o());
    tick();
    check("idle_hold", idle_o());
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("fetch_enter", fetch_o());

    // ADDR A=2 B=5 after a 3-cycle fetch wait.
    run_instr(15, (32'd2 << 23) | (32'd5 << 19), 3, 0, 1'b0, 1'b0, 1'b0);

    // JMPX taken on N, then not taken.
    run_instr(9, (32'd1 << 18) | (32'd3 << 23) | (32'd6 << 19), 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(9, (32'd1 << 18) | (32'd1 << 17), 1, 0, 1'b0, 1'b0, 1'b0);

    // Memory boundary: ready on the last allowed wait cycle succeeds.
    run_instr(2, 32'h0, 0, 14, 1'b0, 1'b0, 1'b0);
    run_instr(5, 32'h0, 14, 0, 1'b0, 1'b0, 1'b0);

    // Randomized instruction stream of legal opcodes.
    for (int k = 0; k < 60; k++) begin
      opc = int'($urandom_range(0, 23));
      ins = $urandom;
      run_instr(opc, ins, int'($urandom_range(0, 4)), int'($urandom_range(0, 14)),
                1'($urandom), 1'($urandom), 1'b0);
    end

    // Reset during MEM_WAIT of STORR, then clean restart.
    bus_if.opcode    = 6'd4;
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    check("storr_first", first_o(4, 32'h0));
    tick();
    check("storr_wait", mem_o(4'b0001));
    reset = 1'b1;
    tick();
    check("reset_mid", zero_o());
    reset = 1'b0;
    tick();
    check("idle_after_reset", idle_o());
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("restart_fetch", fetch_o());
    run_instr(13, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0);

    // LOADK with mem_ready never asserted: MAR, 15 wait cycles, then ERROR.
    bus_if.opcode      = 6'd3;
    bus_if.instruction = 32'h0;
    bus_if.mem_ready   = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    check("loadk_mar", first_o(3, 32'h0));
    for (int i = 0; i < 15; i++) begin
      tick();
      check("loadk_wait", mem_o(4'b0100));
    end
    tick();
    check("timeout_error", err_o());
    bus_if.start = 1'b1;
    bus_if.step  = 1'b1;
    tick(); tick();
    bus_if.start = 1'b0;
    bus_if.step  = 1'b0;
    check("error_held", err_o());

    // Illegal opcode 40.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("fetch_illegal", fetch_o());
    bus_if.opcode    = 6'd40;
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    check("illegal_error", err_o());
    tick();
    check("illegal_held", err_o());

    // Single step: NOP, pause in STEP, step pulse, then END.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.step_mode = 1'b1;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("step_fetch", fetch_o());
    run_instr(0, 32'h0, 2, 0, 1'b0, 1'b0, 1'b1);
    bus_if.start = 1'b1;
    tick(); tick();
    bus_if.start = 1'b0;
    check("step_hold", step_o());
    bus_if.step = 1'b1;
    tick();
    bus_if.step = 1'b0;
    check("step_release", fetch_o());
    bus_if.opcode    = 6'd24;
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    check("halt", halt_o());
    bus_if.start = 1'b1;
    bus_if.step  = 1'b1;
    tick(); tick();
    bus_if.start = 1'b0;
    bus_if.step  = 1'b0;
    check("halt_held", halt_o());
    reset = 1'b1;
    tick();
    check("reset_from_halt", zero_o());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
